// File: rtl/exit_parking_lot_if.sv
// Exit slot-number / slot-location bundle between the exit sensor side and the decoder.
interface exit_parking_lot_if #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned NUM_W     = 3
);
  logic [NUM_W-1:0]     park_number;
  logic [NUM_SLOTS-1:0] park_location;
  logic                 location_valid;
  logic                 location_changed;

  modport master (
    output park_number,
    input  park_location,
    input  location_valid,
    input  location_changed
  );

  modport slave (
    input  park_number,
    output park_location,
    output location_valid,
    output location_changed
  );
endinterface

// File: rtl/exit_parking_lot.sv
// Registers a one-hot location for the slot a car is leaving, plus a valid flag and a
// one-cycle strobe whenever a new exit number is seen.
module exit_parking_lot #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned NUM_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  exit_parking_lot_if.slave   bus
);

  logic [NUM_SLOTS-1:0] location_d, location_q;
  logic [NUM_W-1:0]     prev_num_d, prev_num_q;
  logic                 valid_d, valid_q;
  logic                 changed_d, changed_q;

  always_comb begin
    location_d = '0;
    // Out-of-range numbers match no bit and so decode to all zeros.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      location_d[i] = (32'(bus.park_number) == i);
    end
    prev_num_d = bus.park_number;
    valid_d    = 1'b1;
    // The first update after reset always strobes, whatever the stale history holds.
    changed_d  = !valid_q || (bus.park_number != prev_num_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      location_q <= '0;
      prev_num_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      location_q <= location_d;
      prev_num_q <= prev_num_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
    end
  end

  assign bus.park_location    = location_q;
  assign bus.location_valid   = valid_q;
  assign bus.location_changed = changed_q;

endmodule

// File: tb/tb_exit_parking_lot.sv
// Directed bench for exit_parking_lot: default 8-slot instance plus a 6-slot instance.
module tb_exit_parking_lot;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exit_parking_lot_if #(.NUM_SLOTS(8), .NUM_W(3)) if8 ();
  exit_parking_lot_if #(.NUM_SLOTS(6), .NUM_W(3)) if6 ();

  exit_parking_lot #(.NUM_SLOTS(8), .NUM_W(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  exit_parking_lot #(.NUM_SLOTS(6), .NUM_W(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6.slave)
  );

  typedef struct {
    logic [2:0] num;
    logic [7:0] loc;
    logic       valid;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] loc, input logic v,
                        input logic c);
    check({name, ".loc"}, 32'(if8.park_location), 32'(loc));
    check({name, ".valid"}, 32'(if8.location_valid), 32'(v));
    check({name, ".chg"}, 32'(if8.location_changed), 32'(c));
  endtask

  task automatic check6(input string name, input logic [5:0] loc, input logic v,
                        input logic c);
    check({name, ".loc6"}, 32'(if6.park_location), 32'(loc));
    check({name, ".valid6"}, 32'(if6.location_valid), 32'(v));
    check({name, ".chg6"}, 32'(if6.location_changed), 32'(c));
  endtask

  task automatic step8(input logic [2:0] n);
    @(negedge clk);
    if8.park_number = n;
    @(posedge clk);
    #1;
  endtask

  task automatic step6(input logic [2:0] n);
    @(negedge clk);
    if6.park_number = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sweep 0..7, each value held for two edges: strobe on first edge only.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << i;
      vecs.push_back('{num: 3'(i), loc: oh, valid: 1'b1, chg: 1'b1});
      vecs.push_back('{num: 3'(i), loc: oh, valid: 1'b1, chg: 1'b0});
    end
    // Hold 3 for five edges.
    vecs.push_back('{num: 3'd3, loc: 8'h08, valid: 1'b1, chg: 1'b1});
    for (int i = 0; i < 4; i++) vecs.push_back('{num: 3'd3, loc: 8'h08, valid: 1'b1, chg: 1'b0});
    // Changing every cycle keeps the strobe high.
    vecs.push_back('{num: 3'd5, loc: 8'h20, valid: 1'b1, chg: 1'b1});
    vecs.push_back('{num: 3'd2, loc: 8'h04, valid: 1'b1, chg: 1'b1});
    vecs.push_back('{num: 3'd5, loc: 8'h20, valid: 1'b1, chg: 1'b1});
    vecs.push_back('{num: 3'd7, loc: 8'h80, valid: 1'b1, chg: 1'b1});

    if8.park_number = 3'b101;
    if6.park_number = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check8("reset", 8'h00, 1'b0, 1'b0);
    check6("reset", 6'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step8(vecs[i].num);
      check8($sformatf("vec%0d", i), vecs[i].loc, vecs[i].valid, vecs[i].chg);
    end

    // Six-slot instance: 6 and 7 are out of range and decode to zero.
    step6(3'd6);
    check6("oor6", 6'h00, 1'b1, 1'b1);
    step6(3'd5);
    check6("in5", 6'h20, 1'b1, 1'b1);
    step6(3'd7);
    check6("oor7", 6'h00, 1'b1, 1'b1);
    step6(3'd7);
    check6("oor7hold", 6'h00, 1'b1, 1'b0);

    // Mid-operation async reset with park_number still 7.
    step8(3'd7);
    check8("pre_rst", 8'h80, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check8("async_rst", 8'h00, 1'b0, 1'b0);
    check6("async_rst", 6'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check8("post_rst", 8'h80, 1'b1, 1'b1);
    step8(3'd7);
    check8("post_rst_hold", 8'h80, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exit_parking_lot.md
Name: exit_parking_lot

Overview:
- Exit-side slot decoder for the smart parking system.
- Converts the 3-bit binary number of the parking slot a car is leaving into a registered 8-bit one-hot slot location.
- Downstream occupancy and display logic use that location to clear or indicate the vacated slot.
- Adds a one-cycle change strobe so downstream logic can act once per new exit number.

Parameters:
- NUM_SLOTS, 8: number of parking slots; sets the width of park_location.
- NUM_W, 3: width of park_number; must satisfy 2**NUM_W >= NUM_SLOTS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- park_number  input  NUM_W  binary index of the slot being exited; slot 0 maps to bit 0.
- park_location  output  NUM_SLOTS  registered one-hot location of the exiting slot.
- location_valid  output  1  high once park_location holds a decoded value since reset.
- location_changed  output  1  single-cycle pulse on a cycle where park_location takes a new value.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - park_location = all zeros (no slot).
  - location_valid = 0.
  - location_changed = 0.
  - The internal previous-number register clears to 0.
- Reset release:
  - Synchronous; the first rising clk edge with rst_n high performs a normal update.
- Each rising clk edge with rst_n high:
  - park_location <= one-hot of park_number: bit[park_number] = 1, all other bits 0.
  - location_valid <= 1.
  - location_changed <= 1 when either:
    - this is the first update after reset (location_valid was 0), or
    - park_number differs from the number registered on the previous edge.
  - Otherwise location_changed <= 0.
- Latency:
  - park_location reflects park_number sampled at the most recent rising edge; one cycle of latency.
  - There is no combinational path from input to output.
- Out-of-range input (park_number >= NUM_SLOTS, only possible when NUM_SLOTS < 2**NUM_W):
  - park_location <= all zeros.
  - location_valid <= 1.
  - location_changed follows the same rule as for in-range values.
- Exactly one bit of park_location is set whenever location_valid = 1 and the input was in range. Multi-hot output is never produced.
- Input held constant:
  - park_location is stable.
  - location_changed pulses only once after the value first arrives.
- Input changing every cycle: location_changed stays high every cycle.
- Reset asserted mid-operation:
  - Outputs clear immediately, without waiting for a clock edge.
  - Previous-number history is lost; the first edge after release always pulses location_changed.
- Default configuration: the full 3-bit range 0..7 maps to bits 0..7, so no value is out of range.

Test Plan:
- Hold rst_n low, drive park_number = 3'b101, toggle clk -> park_location = 8'h00, location_valid = 0, location_changed = 0.
- Release reset, park_number = 3'b000, one edge -> park_location = 8'b0000_0001, location_valid = 1, location_changed = 1.
- Sweep park_number 0..7, changing every 20 ns (multiple clock edges per step) -> park_location = 8'h01, 02, 04, 08, 10, 20, 40, 80 in turn, each one cycle after the change; location_changed pulses exactly once per step.
- Hold park_number = 3'b011 for 5 edges -> park_location stays 8'b0000_1000; location_changed high on the first edge only.
- With park_location = 8'h80 (park_number = 7), assert rst_n low between clock edges -> all outputs go to 0 before the next edge. Release reset with park_number still 7 -> the next edge gives 8'h80 with location_changed = 1.
- With NUM_SLOTS = 6, park_number = 3'b110 -> park_location = 6'b000000, location_valid = 1.
